// File: rtl/downstream_req_arbiter.sv
// Round-robin arbiter that funnels NREQ requesters onto one downstream cache port, one transaction at a time.
// Optional watchdog on the outstanding transaction is enabled with `define DS_ARB_TIMEOUT_EN.
module downstream_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_rw,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               c_valid,
    output logic               c_rw,
    output logic [AW-1:0]      c_rdindex,
    output logic [AW-1:0]      c_wrindex,
    output logic [DW-1:0]      c_data,
    input  logic               c_ready,
    input  logic [DW-1:0]      c_rdata,
    output logic               err_timeout
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] cur_idx;
    logic          cur_rw;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    logic [GW-1:0] gnt_idx;
    logic [GW-1:0] cand_idx;
    logic          gnt_found;
    logic          grant;
    logic          timeout_hit;
    int            cand;

    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // Search starts just past the last completed requester so a persistent requester cannot starve others.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand     = (int'(last_grant) + i) % NREQ;
            cand_idx = GW'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // The response cycle (rsp_valid nonzero) is also a no-grant cycle.
    assign grant = !rst && (state == IDLE) && !(|rsp_valid) && gnt_found;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    assign c_valid   = (state == BUSY);
    assign c_rw      = cur_rw;
    assign c_rdindex = cur_addr;
    assign c_wrindex = cur_addr;
    assign c_data    = cur_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NREQ - 1);
            cur_idx    <= '0;
            cur_rw     <= 1'b0;
            cur_addr   <= '0;
            cur_data   <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= '0;
            if (state == IDLE) begin
                if (grant) begin
                    state    <= BUSY;
                    cur_idx  <= gnt_idx;
                    cur_rw   <= req_rw[gnt_idx];
                    cur_addr <= addr_arr[gnt_idx];
                    cur_data <= data_arr[gnt_idx];
                end
            end else if (c_ready) begin
                state              <= IDLE;
                rsp_valid[cur_idx] <= 1'b1;
                rsp_data           <= c_rdata;
                last_grant         <= cur_idx;
            end else if (timeout_hit) begin
                state              <= IDLE;
                rsp_valid[cur_idx] <= 1'b1;
                rsp_data           <= '0;
                last_grant         <= cur_idx;
            end
        end
    end

`ifdef DS_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] to_cnt;

    // c_ready in the limit cycle wins because the BUSY branch checks it first.
    assign timeout_hit = (state == BUSY) && !c_ready && (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (state == IDLE) to_cnt <= '0;
            else if (!c_ready) to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_downstream_req_arbiter.sv
// Scoreboard bench for downstream_req_arbiter: a requester driver, a cache model and a response monitor
// run alongside scenario tasks; responses are checked against expectations queued at grant time.
module tb_downstream_req_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 8;

    typedef struct {
        logic [NREQ-1:0] vld;
        logic [DW-1:0]   data;
        logic            err;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_rw = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               c_valid, c_rw;
    logic [AW-1:0]      c_rdindex, c_wrindex;
    logic [DW-1:0]      c_data;
    logic               c_ready = 1'b0;
    logic [DW-1:0]      c_rdata = '0;
    logic               err_timeout;

    logic [NREQ-1:0] pend = '0;
    logic [NREQ-1:0] hold = '0;
    logic [DW-1:0]   rd_base = '0;
    logic            cache_en = 1'b1;
    logic            exp_to = 1'b0;
    int              cdelay = 0;
    int              cwait = 0;
    exp_t            sb[$];
    int              n_run = 0;
    int              n_fail = 0;

    downstream_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .c_valid(c_valid), .c_rw(c_rw), .c_rdindex(c_rdindex), .c_wrindex(c_wrindex),
        .c_data(c_data), .c_ready(c_ready), .c_rdata(c_rdata), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Requester driver and cache model: c_ready after cdelay waiting cycles, data = rd_base + index.
    initial forever begin
        @(posedge clk); #2;
        req_valid = pend;
        if (c_valid === 1'b1 && cache_en) begin
            if (cwait >= cdelay) begin
                c_ready = 1'b1; c_rdata = rd_base + c_rdindex; cwait = 0;
            end else begin
                c_ready = 1'b0; c_rdata = 32'hDEAD_BEEF; cwait++;
            end
        end else begin
            c_ready = 1'b0; c_rdata = 32'hDEAD_BEEF; cwait = 0;
        end
    end

    // Monitor: queue the expected response on each grant, check every response against the queue.
    initial forever begin
        exp_t e;
        int   g;
        @(negedge clk);
        if (rst === 1'b0) begin
            if (|req_ready === 1'b1) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                e.vld  = req_ready;
                e.data = exp_to ? '0 : rd_base + req_addr[g*AW +: AW];
                e.err  = exp_to;
                sb.push_back(e);
                if (!hold[g]) pend[g] = 1'b0;
            end
            if (|rsp_valid === 1'b1 || err_timeout === 1'b1) begin
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got vld=%b data=%h err=%b, expected no response",
                             rsp_valid, rsp_data, err_timeout);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== e.vld || rsp_data !== e.data || err_timeout !== e.err) begin
                        n_fail++;
                        $display("FAIL rsp_check: got vld=%b data=%h err=%b, expected vld=%b data=%h err=%b",
                                 rsp_valid, rsp_data, err_timeout, e.vld, e.data, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1; pend = '0; hold = '0; exp_to = 1'b0; sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int maxc, output int idx);
        idx = -1;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (|req_ready === 1'b1) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
                break;
            end
        end
    endtask

    task automatic drain();
        logic ok;
        pend = '0; hold = '0; ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c_valid === 1'b0 && rsp_valid === '0 && sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_run++; n_fail++;
            $display("FAIL drain: got c_valid=%b pending=%0d, expected idle", c_valid, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); n_run++;
        if ({req_ready, rsp_valid, rsp_data, c_valid, c_data, c_rdindex, err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b rsp=%b data=%h cv=%b idx=%h err=%b, expected all 0",
                     req_ready, rsp_valid, rsp_data, c_valid, c_rdindex, err_timeout);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); n_run++;
        if (c_valid !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got cv=%b rsp=%b ready=%b, expected 0", c_valid, rsp_valid, req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        rd_base = 32'h25; cdelay = 1; req_rw = '0; req_addr[0 +: AW] = 32'd5; pend = 4'b0001;
        @(negedge clk); n_run++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk); n_run++;
        if (c_valid !== 1'b1 || c_rdindex !== 32'd5 || c_wrindex !== 32'd5 || c_rw !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cache_req: got cv=%b rd=%h wr=%h rw=%b expected 1 5 5 0",
                     c_valid, c_rdindex, c_wrindex, c_rw);
        end
        @(negedge clk); n_run++;
        if (c_valid !== 1'b1 || rsp_valid !== '0) begin
            n_fail++; $display("FAIL single_wait: got cv=%b rsp=%b expected 1 0000", c_valid, rsp_valid);
        end
        @(negedge clk); n_run++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'h2A || c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: got rsp=%b data=%h cv=%b expected 0001 2a 0", rsp_valid, rsp_data, c_valid);
        end
        @(negedge clk); n_run++;
        if (rsp_valid !== '0 || rsp_data !== 32'h2A) begin
            n_fail++; $display("FAIL rsp_data_hold: got rsp=%b data=%h expected 0000 2a", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int gi[5];
        int gc[5];
        int exp_ord[5];
        int ng;
        exp_ord = '{0, 1, 2, 3, 0};
        do_reset();
        rd_base = 32'h100; cdelay = 0;
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 32'(10 + i);
        hold = '1; pend = '1; ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            @(negedge clk);
            if (|req_ready === 1'b1) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi[ng] = i;
                gc[ng] = c; ng++;
            end
        end
        n_run++;
        if (ng != 5) begin n_fail++; $display("FAIL rr_count: got %0d grants expected 5", ng); end
        for (int k = 0; k < ng; k++) begin
            n_run++;
            if (gi[k] != exp_ord[k]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, gi[k], exp_ord[k]);
            end
            if (k > 0) begin
                n_run++;
                if (gc[k] - gc[k-1] != 3) begin
                    n_fail++; $display("FAIL rr_gap[%0d]: got %0d expected 3", k, gc[k] - gc[k-1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_write();
        int g, nbusy, bad;
        rd_base = 32'h1000; cdelay = 3;
        req_addr[3*AW +: AW] = 32'd7; req_data[3*DW +: DW] = 32'h10; req_rw[3] = 1'b1; pend = 4'b1000;
        wait_grant(10, g); n_run++;
        if (g != 3) begin n_fail++; $display("FAIL write_grant: got %0d expected 3", g); end
        @(posedge clk); #1;
        req_data[3*DW +: DW] = 32'h77; req_addr[3*AW +: AW] = 32'h55; req_rw[3] = 1'b0;
        nbusy = 0; bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c_valid === 1'b1) begin
                nbusy++;
                if (c_rw !== 1'b1 || c_wrindex !== 32'd7 || c_rdindex !== 32'd7 || c_data !== 32'h10) bad++;
            end else if (nbusy > 0) break;
        end
        n_run++;
        if (bad != 0) begin n_fail++; $display("FAIL write_fields: got %0d bad cycles expected 0", bad); end
        n_run++;
        if (nbusy != 4) begin n_fail++; $display("FAIL write_busy_len: got %0d expected 4", nbusy); end
        drain();
    endtask

    task automatic test_fairness();
        int g;
        rd_base = 32'h200; cdelay = 2; req_rw = '0;
        req_addr[2*AW +: AW] = 32'h22; req_addr[0 +: AW] = 32'h30;
        hold[2] = 1'b1; pend[2] = 1'b1;
        wait_grant(10, g); n_run++;
        if (g != 2) begin n_fail++; $display("FAIL fair_first: got %0d expected 2", g); end
        @(posedge clk); #1; pend[0] = 1'b1;
        wait_grant(20, g); n_run++;
        if (g != 0) begin n_fail++; $display("FAIL fair_second: got %0d expected 0", g); end
        wait_grant(20, g); n_run++;
        if (g != 2) begin n_fail++; $display("FAIL fair_third: got %0d expected 2", g); end
        drain();
    endtask

    task automatic test_reset_busy();
        int g;
        logic ok;
        cache_en = 1'b0; req_addr[0 +: AW] = 32'h40; pend = 4'b0001;
        wait_grant(10, g); n_run++;
        if (g != 0) begin n_fail++; $display("FAIL rstb_grant: got %0d expected 0", g); end
        @(negedge clk); n_run++;
        if (c_valid !== 1'b1) begin n_fail++; $display("FAIL rstb_busy: got %b expected 1", c_valid); end
        @(posedge clk); #1; rst = 1'b1; pend = '0; sb.delete();
        @(posedge clk); #1;
        rst = 1'b0; cache_en = 1'b1; cdelay = 0; rd_base = 32'h300; pend = '1;
        @(negedge clk); n_run++;
        if (c_valid !== 1'b0 || rsp_valid !== '0) begin
            n_fail++; $display("FAIL rstb_abandon: got cv=%b rsp=%b expected 0 0000", c_valid, rsp_valid);
        end
        n_run++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rstb_first_grant: got %b expected 0001", req_ready);
        end
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (pend == '0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL rstb_all_served: got pend=%b expected 0000", pend); end
        drain();
    endtask

    task automatic test_timeout();
        int g, hit;
        cache_en = 1'b0;
`ifdef DS_ARB_TIMEOUT_EN
        exp_to = 1'b1;
`endif
        req_addr[1*AW +: AW] = 32'h9; pend = 4'b0010;
        wait_grant(10, g); n_run++;
        if (g != 1) begin n_fail++; $display("FAIL to_grant: got %0d expected 1", g); end
        exp_to = 1'b0;
        hit = 0;
`ifdef DS_ARB_TIMEOUT_EN
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (|rsp_valid === 1'b1) begin
                hit = c;
                n_run++;
                if (err_timeout !== 1'b1) begin
                    n_fail++; $display("FAIL to_err: got %b expected 1", err_timeout);
                end
                break;
            end
        end
        n_run++;
        if (hit != 9) begin n_fail++; $display("FAIL to_latency: got cycle %0d expected 9", hit); end
        @(negedge clk); n_run++;
        if (err_timeout !== 1'b0 || rsp_valid !== '0 || c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL to_after: got err=%b rsp=%b cv=%b expected 0", err_timeout, rsp_valid, c_valid);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c_valid !== 1'b1 || err_timeout !== 1'b0 || rsp_valid !== '0) hit++;
        end
        n_run++;
        if (hit != 0) begin n_fail++; $display("FAIL no_timeout_wait: got %0d bad cycles expected 0", hit); end
`endif
        @(posedge clk); #1;
        cache_en = 1'b1;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_fairness();
        test_reset_busy();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
